// File: rtl/speed_pkg.sv
// Shared constants and state encodings for the speed-report UART return path.
// Frame layout: HEADER, id byte, speed byte, checksum.
package speed_pkg;

   localparam logic [7:0] HEADER      = 8'hA5;
   localparam int         FRAME_BYTES = 4;

   typedef enum logic [1:0] {
      F_IDLE,
      F_SEND,
      F_DONE
   } frame_state_e;

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } bit_state_e;

   function automatic logic [7:0] frame_chk(input logic [7:0] id_b, input logic [7:0] speed_b);
      return HEADER ^ id_b ^ speed_b;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer: each bit is held for exactly divisor clocks. A start request seen on
// the last clock of the stop bit chains the next byte with no idle gap on the line.
module uart_tx
   import speed_pkg::*;
#(
   parameter int divisor = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   output logic       o_serial,
   output logic       o_busy,
   output logic       o_byte_done
);

   localparam int            BW        = (divisor > 1) ? $clog2(divisor) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(divisor - 1);

   bit_state_e    state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          serial_q, serial_d;
   logic          baud_last;

   assign baud_last = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= B_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         serial_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         serial_q <= serial_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      data_d      = data_q;
      o_byte_done = 1'b0;
      case (state_q)
         B_IDLE: begin
            if (i_start) begin
               state_d = B_START;
               data_d  = i_byte;
               baud_d  = '0;
            end
         end
         B_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = B_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         B_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               data_d = data_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = B_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         B_STOP: begin
            if (baud_last) begin
               o_byte_done = 1'b1;
               baud_d      = '0;
               if (i_start) begin
                  state_d = B_START;
                  data_d  = i_byte;
               end else begin
                  state_d = B_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = B_IDLE;
      endcase
   end

   // Line level is registered from the next state so the pin never glitches.
   always_comb begin
      case (state_d)
         B_START: serial_d = 1'b0;
         B_DATA:  serial_d = data_d[0];
         default: serial_d = 1'b1;
      endcase
   end

   assign o_serial = serial_q;
   assign o_busy   = (state_q != B_IDLE);

endmodule

// File: rtl/speed_report_tx.sv
// Accepts one (car id, speed) record per handshake and sends it as a 4-byte UART frame:
// HEADER, zero-extended id, speed, XOR checksum.
module speed_report_tx
   import speed_pkg::*;
#(
   parameter int width   = 8,
   parameter int depth   = 8,
   parameter int divisor = 2604
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [depth-1:0] i_id,
   input  logic [width-1:0] i_speed,
   output logic             o_ready,
   output logic             o_tx_serial,
   output logic             o_tx_busy,
   output logic             o_tx_done
);

   localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

   frame_state_e state_q, state_d;
   logic [1:0]   idx_q, idx_d;
   logic [7:0]   id_q, id_d;
   logic [7:0]   speed_q, speed_d;
   logic [1:0]   idx_next;
   logic         accept;
   logic         tx_start;
   logic [7:0]   tx_byte;
   logic         tx_busy;
   logic         tx_byte_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= F_IDLE;
         idx_q   <= '0;
         id_q    <= '0;
         speed_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         id_q    <= id_d;
         speed_q <= speed_d;
      end
   end

   assign o_ready  = (state_q != F_SEND);
   assign accept   = i_valid && o_ready;
   assign idx_next = idx_q + 2'd1;

   // The header is requested on the accept edge itself so its start bit lands one cycle later.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      id_d     = id_q;
      speed_d  = speed_q;
      tx_start = 1'b0;
      tx_byte  = HEADER;
      case (state_q)
         F_IDLE, F_DONE: begin
            if (accept) begin
               state_d  = F_SEND;
               idx_d    = '0;
               id_d     = 8'(i_id);
               speed_d  = 8'(i_speed);
               tx_start = 1'b1;
            end else begin
               state_d = F_IDLE;
            end
         end
         F_SEND: begin
            if (tx_byte_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = F_DONE;
               end else begin
                  idx_d    = idx_next;
                  tx_start = 1'b1;
                  case (idx_next)
                     2'd1:    tx_byte = id_q;
                     2'd2:    tx_byte = speed_q;
                     2'd3:    tx_byte = frame_chk(id_q, speed_q);
                     default: tx_byte = HEADER;
                  endcase
               end
            end
         end
         default: state_d = F_IDLE;
      endcase
   end

   uart_tx #(
      .divisor(divisor)
   ) u_uart_tx (
      .clk        (clk),
      .rst        (rst),
      .i_start    (tx_start),
      .i_byte     (tx_byte),
      .o_serial   (o_tx_serial),
      .o_busy     (tx_busy),
      .o_byte_done(tx_byte_done)
   );

   assign o_tx_busy = (state_q == F_SEND) || (tx_busy && (state_q != F_DONE));
   assign o_tx_done = (state_q == F_DONE);

endmodule

// File: tb/tb_speed_report_tx.sv
// Directed and randomized frames on three configurations, checked cycle by cycle against
// a reference built from the frame and 8N1 bit rules.
module tb_speed_report_tx;

  logic clk;
  logic rst;
  logic valid;
  logic [7:0] id_in;
  logic [7:0] sp_in;
  int sel;

  logic tx0, rdy0, bsy0, dn0;
  logic tx1, rdy1, bsy1, dn1;
  logic tx2, rdy2, bsy2, dn2;
  logic line, rdy, bsy, dn;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  int divs[3] = '{4, 4, 13};
  logic [7:0] masks[3] = '{8'hFF, 8'h3F, 8'hFF};

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  speed_report_tx #(.width(8), .depth(8), .divisor(4)) dut0 (
    .clk(clk), .rst(rst), .i_valid(valid && sel == 0), .i_id(id_in), .i_speed(sp_in),
    .o_ready(rdy0), .o_tx_serial(tx0), .o_tx_busy(bsy0), .o_tx_done(dn0)
  );

  speed_report_tx #(.width(8), .depth(6), .divisor(4)) dut1 (
    .clk(clk), .rst(rst), .i_valid(valid && sel == 1), .i_id(id_in[5:0]), .i_speed(sp_in),
    .o_ready(rdy1), .o_tx_serial(tx1), .o_tx_busy(bsy1), .o_tx_done(dn1)
  );

  speed_report_tx #(.width(8), .depth(8), .divisor(13)) dut2 (
    .clk(clk), .rst(rst), .i_valid(valid && sel == 2), .i_id(id_in), .i_speed(sp_in),
    .o_ready(rdy2), .o_tx_serial(tx2), .o_tx_busy(bsy2), .o_tx_done(dn2)
  );

  always_comb begin
    line = tx0; rdy = rdy0; bsy = bsy0; dn = dn0;
    if (sel == 1) begin
      line = tx1; rdy = rdy1; bsy = bsy1; dn = dn1;
    end else if (sel == 2) begin
      line = tx2; rdy = rdy2; bsy = bsy2; dn = dn2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  // 8N1 line level of bit position pos (0 = start, 1..8 = d0..d7, 9 = stop)
  function automatic logic line_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_line"}, line, 1);
    chk({tag, "_ready"}, rdy, 1);
    chk({tag, "_busy"}, bsy, 0);
    chk({tag, "_done"}, dn, 0);
  endtask

  // Called at a negedge with the block ready; offers a record and checks the whole frame,
  // returning at the negedge of the done cycle. hold keeps i_valid asserted afterwards.
  task automatic run_frame(input logic [7:0] id, input logic [7:0] sp, input bit hold);
    int div;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] got;
    div = divs[sel];
    b0 = 8'hA5;
    b1 = id & masks[sel];
    b2 = sp;
    b3 = b0 ^ b1 ^ b2;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    chk("ready_before", rdy, 1);
    valid = 1'b1;
    id_in = id;
    sp_in = sp;
    got = '0;
    for (int j = 0; j < 40; j++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (j == 0 && c == 0 && !hold) valid = 1'b0;
        chk("line", line, line_bit(exp_q[0], j % 10));
        chk("busy", bsy, 1);
        chk("ready", rdy, 0);
        chk("done", dn, 0);
        if (c == div / 2 && (j % 10) >= 1 && (j % 10) <= 8) got[(j % 10) - 1] = line;
      end
      if (j % 10 == 9) chk("byte", got, exp_q.pop_front());
    end
    @(negedge clk);
    chk("done_pulse", dn, 1);
    chk("done_ready", rdy, 1);
    chk("done_busy", bsy, 0);
    chk("done_line", line, 1);
  endtask

  initial begin
    logic [7:0] rid, rsp;
    checks = 0;
    errors = 0;
    valid = 1'b0;
    id_in = '0;
    sp_in = '0;
    sel = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle("reset");
    end

    // reset while idle
    sel = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle("idle_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_rst_after");

    // single frame id=3 speed=60: A5 03 3C 9A
    run_frame(8'd3, 8'd60, 1'b0);
    @(negedge clk);
    check_idle("after_frame");

    // held valid: second identical frame accepted in the done cycle, start bit right after
    run_frame(8'd7, 8'h55, 1'b1);
    run_frame(8'd7, 8'h55, 1'b0);
    @(negedge clk);
    check_idle("after_b2b");

    // randomized records on the default configuration
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rid = 8'($urandom);
      rsp = 8'($urandom);
      run_frame(rid, rsp, 1'b0);
    end

    // reset during d4 of byte 2 (frame bit 25, cycles 100..103 at divisor 4)
    @(negedge clk);
    rsp = 8'($urandom) & 8'hEF;
    valid = 1'b1;
    id_in = 8'h12;
    sp_in = rsp;
    @(negedge clk);
    valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_d4", line, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_line", line, 1);
    chk("rst_busy", bsy, 0);
    chk("rst_ready", rdy, 1);
    chk("rst_done", dn, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", rdy, 1);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("dropped_done", dn, 0);
      chk("dropped_line", line, 1);
    end
    run_frame(8'h21, 8'h9C, 1'b0);

    // depth 6: id 3F and random ids with upper bits that must be dropped
    sel = 1;
    @(negedge clk);
    run_frame(8'h3F, 8'h44, 1'b0);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_frame(8'($urandom), 8'($urandom), 1'b0);
    end

    // odd divisor timing
    sel = 2;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_frame(8'($urandom), 8'($urandom), 1'b0);
    end
    @(negedge clk);
    check_idle("final");
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
